// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - stage payload bundle (valid, payload, scratch)
//
// One bundle type serves both sides of a pipe_stage_reg:
//   valid  : the stage holds a real instruction
//   data   : packed stage fields (all-zero payload is a NOP)
//   scr    : multi-cycle scratch value
// Modports:
//   master : drives the bundle (the register's output side)
//   slave  : reads the bundle (the register's input side)
// On the input side scr carries the upstream unit's value. On the output side
// scr carries the registered copy fed back to that unit.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 128,
  parameter int SCR_W  = 66
);
  logic              valid;
  logic [DATA_W-1:0] data;
  logic [SCR_W-1:0]  scr;

  modport master (output valid, data, scr);
  modport slave  (input  valid, data, scr);
endinterface

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised inter-stage pipeline register
//
// Carries a payload, valid bit and scratch channel between pipeline stages.
// Each cycle the global stall vector and flush select one mode:
//   FLUSH > ADVANCE (!own) > BUBBLE (own && !down) > HOLD (own && down)
// where own = stall[STAGE] and down = stall[STAGE+1] (0 for the last stage).
//
// Ports:
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset, clears every output
//   stall        : global stall vector [NSTALL-1:0]
//   flush        : exception flush, empties the stage
//   up           : slave bundle  (in_valid / in_data / scr_i)
//   dn           : master bundle (out_valid / out_data / scr_o)
//   stats_clr    : synchronous clear of the statistics counters
//   hold_cnt     : consecutive HOLD cycles of the current valid contents
//   bubble_total : bubbles inserted since reset or clear
//
// Build option: define PIPE_STAGE_STATS_EN to build the statistics counters.
// Without it hold_cnt/bubble_total read 0 and stats_clr is ignored.
module pipe_stage_reg #(
  parameter int DATA_W = 128,
  parameter int SCR_W  = 66,
  parameter int NSTALL = 6,
  parameter int STAGE  = 3,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NSTALL-1:0]  stall,
  input  logic               flush,
  pipe_stage_reg_if.slave    up,
  pipe_stage_reg_if.master   dn,
  input  logic               stats_clr,
  output logic [CNT_W-1:0]   hold_cnt,
  output logic [CNT_W-1:0]   bubble_total
);

  typedef enum logic [1:0] {
    M_FLUSH,
    M_ADVANCE,
    M_BUBBLE,
    M_HOLD
  } mode_e;

  logic own;
  logic down;
  mode_e mode;

  assign own = stall[STAGE];

  // The last stage has no downstream neighbour, so it can never HOLD.
  generate
    if (STAGE < NSTALL - 1) begin : g_down
      assign down = stall[STAGE+1];
    end else begin : g_last
      assign down = 1'b0;
    end
  endgenerate

  always_comb begin
    mode = M_HOLD;
    if (flush)      mode = M_FLUSH;
    else if (!own)  mode = M_ADVANCE;
    else if (!down) mode = M_BUBBLE;
    else            mode = M_HOLD;
  end

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [SCR_W-1:0]  scr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      scr_q   <= '0;
    end else begin
      case (mode)
        M_FLUSH: begin
          valid_q <= 1'b0;
          data_q  <= '0;
          scr_q   <= '0;
        end
        M_ADVANCE: begin
          valid_q <= up.valid;
          data_q  <= up.data;
          scr_q   <= '0;
        end
        M_BUBBLE: begin
          // This stage is iterating: emit a NOP and hand the scratch value
          // back so the upstream unit sees it on its next step.
          valid_q <= 1'b0;
          data_q  <= '0;
          scr_q   <= up.scr;
        end
        default: begin
          scr_q   <= '0;
        end
      endcase
    end
  end

  assign dn.valid = valid_q;
  assign dn.data  = data_q;
  assign dn.scr   = scr_q;

`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] hold_q;
  logic [CNT_W-1:0] bubble_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q   <= '0;
      bubble_q <= '0;
    end else if (stats_clr) begin
      hold_q   <= '0;
      bubble_q <= '0;
    end else begin
      if (mode == M_HOLD) begin
        // Only stalled real instructions count; a held bubble keeps its count.
        if (valid_q && (hold_q != {CNT_W{1'b1}})) hold_q <= hold_q + CNT_W'(1);
      end else begin
        hold_q <= '0;
      end
      if ((mode == M_BUBBLE) && (bubble_q != {CNT_W{1'b1}})) begin
        bubble_q <= bubble_q + CNT_W'(1);
      end
    end
  end

  assign hold_cnt     = hold_q;
  assign bubble_total = bubble_q;

  logic unused_bits;
  assign unused_bits = ^stall;
`else
  assign hold_cnt     = '0;
  assign bubble_total = '0;

  logic unused_bits;
  assign unused_bits = ^{stall, stats_clr};
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed bench for pipe_stage_reg
module tb_pipe_stage_reg;

  localparam int DATA_W = 128;
  localparam int SCR_W  = 66;
  localparam int NSTALL = 6;

`ifdef PIPE_STAGE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [NSTALL-1:0] S_RUN    = 6'b000000;
  localparam logic [NSTALL-1:0] S_BUBBLE = 6'b001000;
  localparam logic [NSTALL-1:0] S_HOLD   = 6'b011000;
  localparam logic [SCR_W-1:0]  SCR_VAL  = 66'h2_0000_0000_0000_0005;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NSTALL-1:0] stall;
  logic              flush;
  logic              stats_clr;
  logic [15:0]       hold_a;
  logic [15:0]       bubble_a;
  logic [1:0]        hold_b;
  logic [1:0]        bubble_b;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg_if #(.DATA_W(DATA_W), .SCR_W(SCR_W)) up_if ();
  pipe_stage_reg_if #(.DATA_W(DATA_W), .SCR_W(SCR_W)) dn_a ();
  pipe_stage_reg_if #(.DATA_W(DATA_W), .SCR_W(SCR_W)) dn_b ();

  pipe_stage_reg #(.DATA_W(DATA_W), .SCR_W(SCR_W), .NSTALL(NSTALL), .STAGE(3), .CNT_W(16)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush        (flush),
    .up           (up_if),
    .dn           (dn_a),
    .stats_clr    (stats_clr),
    .hold_cnt     (hold_a),
    .bubble_total (bubble_a)
  );

  pipe_stage_reg #(.DATA_W(DATA_W), .SCR_W(SCR_W), .NSTALL(NSTALL), .STAGE(3), .CNT_W(2)) u_dut_sat (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush        (flush),
    .up           (up_if),
    .dn           (dn_b),
    .stats_clr    (stats_clr),
    .hold_cnt     (hold_b),
    .bubble_total (bubble_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] st(input int v);
    return STATS ? 128'(v) : 128'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [127:0] d, input logic [SCR_W-1:0] s);
    check({tag, ".valid"}, 128'(dn_a.valid), 128'(v));
    check({tag, ".data"},  dn_a.data, d);
    check({tag, ".scr"},   128'(dn_a.scr), 128'(s));
  endtask

  initial begin
    rst_n        = 1'b0;
    stall        = S_RUN;
    flush        = 1'b0;
    stats_clr    = 1'b0;
    up_if.valid  = 1'b0;
    up_if.data   = '0;
    up_if.scr    = '0;
    #3;
    check_out("reset", 1'b0, 128'd0, '0);
    check("reset.hold", 128'(hold_a), 128'd0);
    check("reset.bubble", 128'(bubble_a), 128'd0);
    step();
    rst_n = 1'b1;

    // ADVANCE stream; scratch input must not leak through
    up_if.scr = 66'h7;
    for (int i = 1; i <= 3; i++) begin
      up_if.valid = 1'b1;
      up_if.data  = 128'(i);
      step();
      check_out($sformatf("adv%0d", i), 1'b1, 128'(i), '0);
    end

    // BUBBLE with scratch handback
    stall     = S_BUBBLE;
    up_if.scr = SCR_VAL;
    step();
    check_out("bubble", 1'b0, 128'd0, SCR_VAL);
    check("bubble.total", 128'(bubble_a), st(1));

    // load 0xA5, then HOLD four cycles
    stall      = S_RUN;
    up_if.data = 128'hA5;
    step();
    check_out("load_a5", 1'b1, 128'hA5, '0);
    check("load_a5.hold", 128'(hold_a), 128'd0);
    stall      = S_HOLD;
    up_if.data = 128'hFF;
    for (int i = 1; i <= 4; i++) begin
      step();
      check_out($sformatf("hold%0d", i), 1'b1, 128'hA5, '0);
      check($sformatf("hold%0d.cnt", i), 128'(hold_a), st(i));
      check($sformatf("hold%0d.cnt_sat", i), 128'(hold_b), st(i > 3 ? 3 : i));
    end
    stall      = S_RUN;
    up_if.data = 128'h77;
    step();
    check_out("release", 1'b1, 128'h77, '0);
    check("release.hold", 128'(hold_a), 128'd0);

    // flush beats a HOLD stall combination
    stall = S_HOLD;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_out("flush", 1'b0, 128'd0, '0);
    check("flush.hold", 128'(hold_a), 128'd0);
    check("flush.bubble", 128'(bubble_a), st(1));

    // five more bubbles: wide counter 6, 2-bit counter saturates at 3
    stall = S_BUBBLE;
    for (int i = 0; i < 5; i++) step();
    check("sat.bubble", 128'(bubble_a), st(6));
    check("sat.bubble_sat", 128'(bubble_b), st(3));
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    check_out("clr_bubble", 1'b0, 128'd0, SCR_VAL);
    check("clr.bubble", 128'(bubble_a), 128'd0);
    check("clr.bubble_sat", 128'(bubble_b), 128'd0);

    // reset mid-HOLD: outputs clear before the next edge
    stall      = S_RUN;
    up_if.data = 128'hDEAD;
    step();
    check_out("load_dead", 1'b1, 128'hDEAD, '0);
    stall = S_HOLD;
    for (int i = 0; i < 3; i++) step();
    check("dead.hold", 128'(hold_a), st(3));
    #3;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 1'b0, 128'd0, '0);
    check("async_rst.hold", 128'(hold_a), 128'd0);
    check("async_rst.hold_sat", 128'(hold_b), 128'd0);
    #1;
    rst_n      = 1'b1;
    stall      = S_RUN;
    up_if.data = 128'h1234;
    step();
    check_out("post_rst", 1'b1, 128'h1234, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
